// File: rtl/e_mdu_pkg.sv
// -----------------------------------------------------------------------------
// e_mdu_pkg
//  Shared definitions for the execute-stage multiply/divide unit:
//  the 4-bit MDU opcode encoding, the counter-derived state names and a
//  small opcode classification helper.
// -----------------------------------------------------------------------------
package e_mdu_pkg;

  // Opcode carried by the instruction currently in E. MDU_NONE means no MDU
  // instruction is present.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  // Named view of the busy counter: zero is IDLE, anything else is BUSY.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // True for the opcodes that occupy the unit for a multi-cycle window.
  function automatic logic is_muldiv(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
  endfunction

  // True for the multiply flavours (selects the shorter busy window).
  function automatic logic is_mult(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU};
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// -----------------------------------------------------------------------------
// e_mdu_arith
//  Purely combinational arithmetic core of the MDU.
//  Ports:
//   a, b        in  32  operands (a = rs, b = rt)
//   is_signed   in  1   1 for MULT/DIV, 0 for MULTU/DIVU
//   product     out 64  full-width product, {HI,LO}
//   quotient    out 32  a / b, truncated toward zero (0 when b == 0)
//   remainder   out 32  a % b, sign follows the dividend (0 when b == 0)
//   div_zero    out 1   divisor is zero; the caller must not commit
// -----------------------------------------------------------------------------
module e_mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [63:0] product,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    // Sign- or zero-extend to 64 bits; the low 64 bits of the product of the
    // extended operands are the exact signed/unsigned 64-bit product.
    a_ext   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    product = a_ext * b_ext;

    // Signed division is done on magnitudes. Treating the magnitude as
    // unsigned makes 0x80000000 / -1 fall out as 0x80000000 with no overflow
    // special case.
    neg_a    = is_signed & a[31];
    neg_b    = is_signed & b[31];
    mag_a    = neg_a ? (32'd0 - a) : a;
    mag_b    = neg_b ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);

    q_mag = 32'd0;
    r_mag = 32'd0;
    if (!div_zero) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end

    quotient  = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    remainder = neg_a ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu
//  Execute-stage multiply/divide unit. Owns architectural HI/LO, runs
//  MULT/MULTU/DIV/DIVU over a fixed busy window and services MTHI/MTLO/
//  MFHI/MFLO.
//  Parameters:
//   MULT_CYCLES  busy cycles after a multiply launch (>= 1)
//   DIV_CYCLES   busy cycles after a divide launch (>= 1, >= MULT_CYCLES)
//  Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   synchronous, active-low
//   req          in  1   exception/interrupt; cancels the E-stage instruction
//   E_MDU_op     in  4   opcode of the instruction in E
//   E_rs_data    in  32  forwarded rs
//   E_rt_data    in  32  forwarded rt
//   E_MDU_busy   out 1   a mult/div is in flight
//   E_MDU_start  out 1   this cycle launches a mult/div (combinational)
//   E_HI_LO      out 32  HI for MFHI, LO for MFLO, else 0 (combinational)
// -----------------------------------------------------------------------------
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  E_MDU_op,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  output logic        E_MDU_busy,
  output logic        E_MDU_start,
  output logic [31:0] E_HI_LO
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_pend_q, hi_pend_d;
  logic [31:0]      lo_pend_q, lo_pend_d;
  logic             pend_wr_q, pend_wr_d;   // 0 for a divide-by-zero op

  logic             accept;
  mdu_state_e       state;

  logic [63:0]      product;
  logic [31:0]      quotient;
  logic [31:0]      remainder;
  logic             div_zero;

  e_mdu_arith u_arith (
    .a         (E_rs_data),
    .b         (E_rt_data),
    .is_signed (E_MDU_op == MDU_MULT || E_MDU_op == MDU_DIV),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // The instruction in E may act only when out of reset and not cancelled.
  assign accept      = reset & ~req;
  assign state       = (cnt_q != '0) ? ST_BUSY : ST_IDLE;
  assign E_MDU_busy  = (state == ST_BUSY);
  assign E_MDU_start = accept & ~E_MDU_busy & is_muldiv(E_MDU_op);

  // Next-state logic. Ops arriving while BUSY are deliberately ignored; the
  // hazard unit is expected to keep them out.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    pend_wr_d = pend_wr_q;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          case (E_MDU_op)
            MDU_MULT, MDU_MULTU: begin
              cnt_d     = CNT_W'(MULT_CYCLES);
              hi_pend_d = product[63:32];
              lo_pend_d = product[31:0];
              pend_wr_d = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
              cnt_d     = CNT_W'(DIV_CYCLES);
              hi_pend_d = remainder;
              lo_pend_d = quotient;
              pend_wr_d = ~div_zero;
            end
            MDU_MTHI: hi_d = E_rs_data;
            MDU_MTLO: lo_d = E_rs_data;
            default:  ;
          endcase
        end
      end
      ST_BUSY: begin
        // req does not abort an op in flight: the countdown is unconditional.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1) && pend_wr_q) begin
          hi_d = hi_pend_q;
          lo_d = lo_pend_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here, pending values included, is cleared by reset
    // so an aborted op can never commit stale data afterwards.
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // the values computed before the edge.
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // MF* read the architectural registers only, never the pending results.
  always_comb begin
    E_HI_LO = 32'd0;
    case (E_MDU_op)
      MDU_MFHI: E_HI_LO = hi_q;
      MDU_MFLO: E_HI_LO = lo_q;
      default:  ;
    endcase
  end

endmodule
